// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame accumulator and its helpers.
package parity_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } parState_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_tree.sv
// Purely combinational XOR reduction of one data word; reused by wider link checkers.
module parity_tree #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_data,
    output logic             parity
);

    assign parity = ^in_data;

endmodule

// File: rtl/parity_frame_accum.sv
// Registered per-word parity plus frame parity/length accumulation over a
// valid-qualified word stream, with frames closed by in_last or a length limit.
module parity_frame_accum
    import parity_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int MAX_FRAME = 16,
    localparam int CW        = $clog2(MAX_FRAME + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             word_par,
    output logic             word_valid,
    output logic             frame_par,
    output logic [CW-1:0]    frame_len,
    output logic             frame_valid,
    output logic             overflow
);

    parState_t     r_state;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_modeQ;

    logic          w_par;
    logic          w_sense;
    logic          w_accNext;
    logic [CW-1:0] w_cntNext;
    logic          w_hitMax;

    parity_tree #(.WIDTH(WIDTH)) u_parityTree (
        .in_data (in_data),
        .parity  (w_par)
    );

    // The first word of a frame uses the live sense; later words use the latched one.
    assign w_sense   = (r_state == IDLE) ? odd_mode : r_modeQ;
    assign w_accNext = r_acc ^ w_par;
    assign w_cntNext = r_cnt + CW'(1);
    assign w_hitMax  = (w_cntNext == CW'(MAX_FRAME));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_modeQ     <= PAR_EVEN;
            word_par    <= 1'b0;
            word_valid  <= 1'b0;
            frame_par   <= 1'b0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_valid <= 1'b0;
            if (in_valid) begin
                word_valid <= 1'b1;
                word_par   <= w_par ^ w_sense;
                case (r_state)
                    IDLE: begin
                        r_modeQ <= odd_mode;
                        r_acc   <= w_par;
                        r_cnt   <= CW'(1);
                        if (in_last) begin
                            frame_par   <= w_par ^ odd_mode;
                            frame_len   <= CW'(1);
                            overflow    <= 1'b0;
                            frame_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        // in_last wins over the length limit, so a coinciding close is not an overflow.
                        if (in_last || w_hitMax) begin
                            frame_par   <= w_accNext ^ r_modeQ;
                            frame_len   <= w_cntNext;
                            overflow    <= ~in_last;
                            frame_valid <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_acc <= w_accNext;
                            r_cnt <= w_cntNext;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_accum.sv
// Directed scenario tasks plus a short modelled random run for parity_frame_accum.
module tb_parity_frame_accum;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_last = 1'b0;
    logic       odd_mode = 1'b0;
    logic       word_par;
    logic       word_valid;
    logic       frame_par;
    logic [4:0] frame_len;
    logic       frame_valid;
    logic       overflow;

    int nCompared = 0;
    int nMismatched = 0;

    parity_frame_accum #(.WIDTH(4), .MAX_FRAME(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .odd_mode    (odd_mode),
        .word_par    (word_par),
        .word_valid  (word_valid),
        .frame_par   (frame_par),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and return 1 time unit after the edge that consumed them.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l, input logic m);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        odd_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        nCompared++;
        if ({word_par, word_valid, frame_par, frame_len, frame_valid, overflow} !== 10'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %b want 0", {word_par, word_valid, frame_par, frame_len, frame_valid, overflow});
        end
    endtask

    task automatic test_sweep;
        logic [15:0] expPar = 16'h6996;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), (i == 15), 1'b0);
            nCompared++;
            if (word_valid !== 1'b1 || word_par !== expPar[i]) begin
                nMismatched++;
                $display("[TB] FAIL sweep_word%0d: got v=%b p=%b want v=1 p=%b", i, word_valid, word_par, expPar[i]);
            end
            nCompared++;
            if (frame_valid !== (i == 15)) begin
                nMismatched++;
                $display("[TB] FAIL sweep_fvalid%0d: got %b want %b", i, frame_valid, (i == 15));
            end
        end
        nCompared++;
        if (frame_par !== 1'b0 || frame_len !== 5'd16 || overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sweep_frame: got par=%b len=%0d ovf=%b want par=0 len=16 ovf=0", frame_par, frame_len, overflow);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        nCompared++;
        if (frame_valid !== 1'b0 || word_valid !== 1'b0 || frame_len !== 5'd16 || word_par !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sweep_hold: got fv=%b wv=%b len=%0d wp=%b want 0 0 16 0", frame_valid, word_valid, frame_len, word_par);
        end
    endtask

    task automatic test_odd_single;
        applyStimulus(1'b1, 4'b0111, 1'b1, 1'b1);
        nCompared++;
        if (word_par !== 1'b0 || frame_valid !== 1'b1 || frame_par !== 1'b0 || frame_len !== 5'd1 || overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL odd_single: got wp=%b fv=%b fp=%b len=%0d ovf=%b want 0 1 0 1 0", word_par, frame_valid, frame_par, frame_len, overflow);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
            nCompared++;
            if (frame_valid !== (i == 16)) begin
                nMismatched++;
                $display("[TB] FAIL ovf_fvalid%0d: got %b want %b", i, frame_valid, (i == 16));
            end
        end
        nCompared++;
        if (frame_len !== 5'd16 || frame_par !== 1'b0 || overflow !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ovf_frame: got len=%0d par=%b ovf=%b want 16 0 1", frame_len, frame_par, overflow);
        end
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        nCompared++;
        if (frame_valid !== 1'b1 || frame_len !== 5'd1 || frame_par !== 1'b1 || overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ovf_next: got fv=%b len=%0d par=%b ovf=%b want 1 1 1 0", frame_valid, frame_len, frame_par, overflow);
        end
    endtask

    task automatic test_gaps_mode;
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        nCompared++;
        if (word_valid !== 1'b0 || frame_valid !== 1'b0 || word_par !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL gap_idle: got wv=%b fv=%b wp=%b want 0 0 1", word_valid, frame_valid, word_par);
        end
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b1);
        nCompared++;
        if (word_par !== 1'b0 || frame_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL gap_word2: got wp=%b fv=%b want 0 0", word_par, frame_valid);
        end
        applyStimulus(1'b1, 4'h8, 1'b1, 1'b1);
        nCompared++;
        if (word_par !== 1'b1 || frame_valid !== 1'b1 || frame_par !== 1'b0 || frame_len !== 5'd3 || overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL gap_frame: got wp=%b fv=%b fp=%b len=%0d ovf=%b want 1 1 0 3 0", word_par, frame_valid, frame_par, frame_len, overflow);
        end
    endtask

    task automatic test_reset_mid;
        int fvCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
            fvCount += int'(frame_valid);
        end
        reset = 1'b1;
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b1);
        reset = 1'b0;
        fvCount += int'(frame_valid);
        nCompared++;
        if ({word_par, word_valid, frame_par, frame_len, frame_valid, overflow} !== 10'd0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_outputs: got %b want 0", {word_par, word_valid, frame_par, frame_len, frame_valid, overflow});
        end
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
        fvCount += int'(frame_valid);
        nCompared++;
        if (frame_len !== 5'd1 || frame_par !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_frame: got len=%0d par=%b want 1 0", frame_len, frame_par);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        fvCount += int'(frame_valid);
        nCompared++;
        if (fvCount != 1) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_count: got %0d frame_valid pulses want 1", fvCount);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] dataSeq [3] = '{4'h3, 4'h2, 4'hE};
        logic       expPar  [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, dataSeq[i], 1'b1, 1'b0);
            nCompared++;
            if (frame_valid !== 1'b1 || frame_par !== expPar[i] || frame_len !== 5'd1) begin
                nMismatched++;
                $display("[TB] FAIL b2b%0d: got fv=%b par=%b len=%0d want 1 %b 1", i, frame_valid, frame_par, frame_len, expPar[i]);
            end
        end
    endtask

    // Behavioural reference of the frame rules, checked every cycle.
    task automatic test_random;
        logic mOpen = 1'b0, mAcc = 1'b0, mMode = 1'b0;
        int   mCnt = 0;
        logic eWp = 1'b0, eFp = 1'b0, eOvf = 1'b0, eWv, eFv;
        int   eLen = 0;
        logic v, l, m, p;
        logic [3:0] d;
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(3) != 0);
            l = ($urandom_range(9) == 0);
            m = 1'($urandom_range(1));
            d = 4'($urandom_range(15));
            p = d[0] ^ d[1] ^ d[2] ^ d[3];
            eWv = v;
            eFv = 1'b0;
            if (v) begin
                eWp = p ^ (mOpen ? mMode : m);
                if (!mOpen) begin
                    mMode = m; mAcc = p; mCnt = 1;
                    if (l) begin eFv = 1'b1; eFp = p ^ m; eLen = 1; eOvf = 1'b0; end
                    else mOpen = 1'b1;
                end else if (l || mCnt + 1 == 16) begin
                    eFv = 1'b1; eFp = mAcc ^ p ^ mMode; eLen = mCnt + 1; eOvf = !l; mOpen = 1'b0;
                end else begin
                    mAcc = mAcc ^ p; mCnt = mCnt + 1;
                end
            end
            applyStimulus(v, d, l, m);
            nCompared++;
            if (word_valid !== eWv || word_par !== eWp || frame_valid !== eFv || frame_par !== eFp || frame_len !== 5'(eLen) || overflow !== eOvf) begin
                nMismatched++;
                $display("[TB] FAIL rand%0d: got wv=%b wp=%b fv=%b fp=%b len=%0d ovf=%b want %b %b %b %b %0d %b", i,
                         word_valid, word_par, frame_valid, frame_par, frame_len, overflow, eWv, eWp, eFv, eFp, eLen, eOvf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_odd_single();
        test_overflow();
        test_gaps_mode();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
